// File: rtl/fifo_apb_sched_pkg.sv
// Shared types and constants for the APB FIFO client scheduler.
package fifo_sched_pkg;

  localparam int APB_AW = 4;
  localparam int APB_DW = 32;

  // Default register map of the FIFO peripheral.
  localparam logic [APB_AW-1:0] DEF_ADDR_STATUS = 4'h0;
  localparam logic [APB_AW-1:0] DEF_ADDR_WDATA  = 4'h4;
  localparam logic [APB_AW-1:0] DEF_ADDR_RDATA  = 4'h8;

  // Status register bit positions.
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;

  typedef enum logic [2:0] {
    IDLE,
    ST_SETUP,
    ST_ACCESS,
    DT_SETUP,
    DT_ACCESS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_FULL    = 2'd1,
    RSP_EMPTY   = 2'd2,
    RSP_TIMEOUT = 2'd3
  } rsp_code_e;

endpackage

// File: rtl/fifo_apb_sched_if.sv
// APB bus between the scheduler (master) and the FIFO peripheral (slave).
interface fifo_apb_sched_if;
  import fifo_sched_pkg::*;

  logic [APB_AW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/fifo_apb_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester strictly after
// the last grant wins, wrapping around.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant
);

  // Two passes: indices above the pointer first, then the wrapped range.
  always_comb begin
    logic found;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_apb_sched.sv
// APB master sharing a FIFO peripheral between N_CLIENTS requesters.
// Each request reads status first and only touches the data register when
// the FIFO can take it; one transaction in flight, round-robin grants.
module fifo_apb_sched
  import fifo_sched_pkg::*;
#(
  parameter int                N_CLIENTS   = 2,
  parameter int                TIMEOUT     = 15,
  parameter logic [APB_AW-1:0] ADDR_STATUS = DEF_ADDR_STATUS,
  parameter logic [APB_AW-1:0] ADDR_WDATA  = DEF_ADDR_WDATA,
  parameter logic [APB_AW-1:0] ADDR_RDATA  = DEF_ADDR_RDATA
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  fifo_apb_sched_if.master       apb,
  input  logic [N_CLIENTS-1:0]   req_valid,
  input  logic [N_CLIENTS-1:0]   req_write,
  input  logic [N_CLIENTS*8-1:0] req_wdata,
  output logic [N_CLIENTS-1:0]   req_ready,
  output logic [N_CLIENTS-1:0]   rsp_valid,
  output logic [1:0]             rsp_code,
  output logic [7:0]             rsp_rdata
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_INIT  = IW'(N_CLIENTS - 1);

  state_e               state, state_nx;
  logic [IW-1:0]        rr_ptr, owner, gnt_idx;
  logic [N_CLIENTS-1:0] grant;
  logic                 op_write;
  logic [7:0]           op_wdata;
  logic [CW-1:0]        wait_cnt;
  rsp_code_e            code_q;
  logic [7:0]           rdata_q;
  logic                 in_access, timed_out, blocked;
  logic                 unused_prdata;

  rr_arbiter #(.N(N_CLIENTS)) u_arb (
    .req   (req_valid),
    .last  (rr_ptr),
    .grant (grant)
  );

  assign in_access     = (state == ST_ACCESS) || (state == DT_ACCESS);
  assign timed_out     = in_access && !apb.PREADY && (wait_cnt == WAIT_LAST);
  assign blocked       = op_write ? apb.PRDATA[STAT_FULL] : apb.PRDATA[STAT_EMPTY];
  assign unused_prdata = ^apb.PRDATA[APB_DW-1:8];
  assign rsp_code      = code_q;
  assign rsp_rdata     = rdata_q;

  // One-hot grant to index of the winning client.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) gnt_idx = IW'(i);
    end
  end

  // State register; reset aborts any transaction without a response.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!PRESET) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (|req_valid) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: begin
        if (apb.PREADY) state_nx = blocked ? RESP : DT_SETUP;
        else if (timed_out) state_nx = RESP;
      end
      DT_SETUP:  state_nx = DT_ACCESS;
      DT_ACCESS: if (apb.PREADY || timed_out) state_nx = RESP;
      RESP:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Request latch, wait counter, response code/data and rr pointer.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      rr_ptr   <= PTR_INIT;
      owner    <= '0;
      op_write <= 1'b0;
      op_wdata <= '0;
      wait_cnt <= '0;
      code_q   <= RSP_OK;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner    <= gnt_idx;
            op_write <= req_write[gnt_idx];
            op_wdata <= req_wdata[{gnt_idx, 3'b000} +: 8];
          end
        end
        ST_SETUP, DT_SETUP: wait_cnt <= '0;
        ST_ACCESS: begin
          if (apb.PREADY) begin
            if (blocked) code_q <= op_write ? RSP_FULL : RSP_EMPTY;
          end else if (timed_out) begin
            code_q <= RSP_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DT_ACCESS: begin
          if (apb.PREADY) begin
            code_q <= RSP_OK;
            if (!op_write) rdata_q <= apb.PRDATA[7:0];
          end else if (timed_out) begin
            code_q <= RSP_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP:    rr_ptr <= owner;
        default: ;
      endcase
    end
  end

  // Moore outputs: APB drive per state, accept and completion pulses.
  always_comb begin
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    req_ready   = '0;
    rsp_valid   = '0;
    case (state)
      // Accept is suppressed while reset is held so no grant is lost.
      IDLE: if (PRESET) req_ready = grant;
      ST_SETUP, ST_ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == ST_ACCESS);
        apb.PADDR   = ADDR_STATUS;
      end
      DT_SETUP, DT_ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = (state == DT_ACCESS);
        apb.PWRITE  = op_write;
        apb.PADDR   = op_write ? ADDR_WDATA : ADDR_RDATA;
        apb.PWDATA  = op_write ? {24'b0, op_wdata} : '0;
      end
      RESP:    rsp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_apb_sched.sv
// Self-checking bench: FIFO peripheral model on the APB side, directed
// table, multi-cycle corner sequences and a randomized phase against a
// queue-based reference model.
module tb_fifo_apb_sched;
  import fifo_sched_pkg::*;

  localparam int N     = 2;
  localparam int TO    = 15;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_apb_sched_if apb();

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_write = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [1:0]     rsp_code;
  logic [7:0]     rsp_rdata;

  fifo_apb_sched #(.N_CLIENTS(N), .TIMEOUT(TO)) dut (
    .PCLK      (clk),
    .PRESET    (rst_n),
    .apb       (apb),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_code  (rsp_code),
    .rsp_rdata (rsp_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO peripheral (APB slave) ----------------
  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] data;
  } apb_log_t;

  logic [7:0] fq[$];
  apb_log_t   log_q[$];
  int         ready_at = 2;
  bit         ready_en = 1'b1;
  int         acc_cnt  = 0;
  int         max_acc  = 0;

  initial begin
    apb.PREADY = 1'b0;
    apb.PRDATA = '0;
    forever begin
      @(negedge clk);
      if (apb.PSEL && apb.PENABLE) begin
        acc_cnt++;
        if (acc_cnt > max_acc) max_acc = acc_cnt;
        if (ready_en && acc_cnt == ready_at) begin
          apb.PREADY = 1'b1;
          apb.PRDATA = '0;
          case (apb.PADDR)
            4'h0: apb.PRDATA = {30'b0, fq.size() == DEPTH, fq.size() == 0};
            4'h4: if (apb.PWRITE && fq.size() < DEPTH) fq.push_back(apb.PWDATA[7:0]);
            4'h8: if (!apb.PWRITE && fq.size() > 0) apb.PRDATA = {24'b0, fq.pop_front()};
            default: ;
          endcase
          log_q.push_back('{apb.PADDR, apb.PWRITE, apb.PWRITE ? apb.PWDATA : apb.PRDATA});
        end else begin
          apb.PREADY = 1'b0;
        end
      end else begin
        acc_cnt    = 0;
        apb.PREADY = 1'b0;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int rsp_cnt = 0;
  bit prev_setup = 1'b0;
  bit prev_wait  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (|rsp_valid) rsp_cnt++;
      if (rst_n) begin
        if (|req_ready || |rsp_valid) begin
          check("req_ready_onehot", 32'($onehot0(req_ready)), 1);
          check("rsp_valid_onehot", 32'($onehot0(rsp_valid)), 1);
        end
        if (apb.PENABLE) check("penable_after_setup", 32'(apb.PSEL && (prev_setup || prev_wait)), 1);
      end
      prev_setup = apb.PSEL && !apb.PENABLE;
      prev_wait  = apb.PSEL && apb.PENABLE && !apb.PREADY;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic int rr_next(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_apb_ctl", {29'b0, apb.PSEL, apb.PENABLE, apb.PWRITE}, 0);
    check("rst_paddr", 32'(apb.PADDR), 0);
    check("rst_pwdata", apb.PWDATA, 0);
    check("rst_ready_valid", {28'b0, req_ready, rsp_valid}, 0);
    check("rst_code_rdata", {22'b0, rsp_code, rsp_rdata}, 0);
    rst_n = 1'b1;
  endtask

  // Present a request set, wait for accept, then for the matching response.
  // Latency counts cycles from the accept cycle (cycle 0).
  task automatic run_req(input logic [N-1:0] mask, input logic [N-1:0] wr,
                         input logic [8*N-1:0] wd, output int g,
                         output logic [1:0] code, output logic [7:0] rd,
                         output int lat, output logic psel_rsp);
    bit got;
    logic [N-1:0] exp_oh;
    got = 1'b0; g = -1; code = '0; rd = '0; lat = -1; psel_rsp = 1'b0;
    @(negedge clk);
    req_valid = mask;
    req_write = wr;
    req_wdata = wd;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req_ready != '0) begin
        got = 1'b1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      end else begin
        @(negedge clk);
      end
    end
    check("accept_seen", 32'(got), 1);
    if (got) begin
      got = 1'b0;
      exp_oh = '0;
      exp_oh[g] = 1'b1;
      for (int k = 1; k <= 40 && !got; k++) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        if (rsp_valid != '0) begin
          got = 1'b1;
          lat = k;
          code = rsp_code;
          rd = rsp_rdata;
          psel_rsp = apb.PSEL;
          check("rsp_owner", 32'(rsp_valid), 32'(exp_oh));
        end
      end
      check("rsp_seen", 32'(got), 1);
    end
    req_valid = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         c;
    bit         wr;
    logic [7:0] d;
    logic [1:0] code;
    logic [7:0] rd;
    int         lat;
    int         n_apb;
  } vec_t;

  vec_t vt[$];

  initial begin
    int g, lat;
    logic [1:0] code;
    logic [7:0] rd;
    logic psel_rsp;
    logic [N-1:0] m, w;
    logic [8*N-1:0] wd;
    int got_g[$];
    int last;
    logic [7:0] mq[$];

    vt.push_back('{1, 1'b0, 8'h00, RSP_EMPTY, 8'h00, 4, 1});
    vt.push_back('{0, 1'b1, 8'hA5, RSP_OK,    8'h00, 7, 2});
    vt.push_back('{0, 1'b0, 8'h00, RSP_OK,    8'hA5, 7, 2});
    vt.push_back('{1, 1'b1, 8'h11, RSP_OK,    8'h00, 7, 2});
    vt.push_back('{0, 1'b1, 8'h22, RSP_OK,    8'h00, 7, 2});
    vt.push_back('{1, 1'b1, 8'h33, RSP_OK,    8'h00, 7, 2});
    vt.push_back('{0, 1'b1, 8'h44, RSP_OK,    8'h00, 7, 2});
    vt.push_back('{1, 1'b1, 8'h3C, RSP_FULL,  8'h00, 4, 1});
    vt.push_back('{0, 1'b0, 8'h00, RSP_OK,    8'h11, 7, 2});
    vt.push_back('{1, 1'b0, 8'h00, RSP_OK,    8'h22, 7, 2});
    vt.push_back('{0, 1'b0, 8'h00, RSP_OK,    8'h33, 7, 2});
    vt.push_back('{1, 1'b0, 8'h00, RSP_OK,    8'h44, 7, 2});
    vt.push_back('{0, 1'b0, 8'h00, RSP_EMPTY, 8'h00, 4, 1});

    apply_reset();

    foreach (vt[i]) begin
      m = '0; m[vt[i].c] = 1'b1;
      w = '0; w[vt[i].c] = vt[i].wr;
      wd = '0; wd[vt[i].c*8 +: 8] = vt[i].d;
      log_q.delete();
      run_req(m, w, wd, g, code, rd, lat, psel_rsp);
      check($sformatf("vec%0d_grant", i), 32'(g), 32'(vt[i].c));
      check($sformatf("vec%0d_code", i), 32'(code), 32'(vt[i].code));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("vec%0d_apb_count", i), 32'(log_q.size()), 32'(vt[i].n_apb));
      if (log_q.size() >= 1)
        check($sformatf("vec%0d_status_access", i), {27'b0, log_q[0].addr, log_q[0].wr}, {27'b0, 4'h0, 1'b0});
      if (log_q.size() >= 2 && vt[i].wr) begin
        check($sformatf("vec%0d_push_access", i), {27'b0, log_q[1].addr, log_q[1].wr}, {27'b0, 4'h4, 1'b1});
        check($sformatf("vec%0d_pwdata", i), log_q[1].data, {24'b0, vt[i].d});
      end
      if (log_q.size() >= 2 && !vt[i].wr)
        check($sformatf("vec%0d_pop_access", i), {27'b0, log_q[1].addr, log_q[1].wr}, {27'b0, 4'h8, 1'b0});
      if (!vt[i].wr && vt[i].code == RSP_OK)
        check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].rd));
    end
    check("drain_empty", 32'(fq.size()), 0);

    // Round robin with both clients requesting continuously.
    apply_reset();
    @(negedge clk);
    req_write = '0;
    req_valid = '1;
    for (int k = 0; k < 120 && got_g.size() < 6; k++) begin
      #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) got_g.push_back(i);
      @(negedge clk);
    end
    req_valid = '0;
    check("rr_grant_count", 32'(got_g.size()), 6);
    last = N - 1;
    foreach (got_g[i]) begin
      check($sformatf("rr_grant%0d", i), 32'(got_g[i]), 32'(rr_next(last, '1)));
      last = rr_next(last, '1);
    end
    repeat (10) @(negedge clk);

    // Timeout: the slave never answers.
    ready_en = 1'b0;
    max_acc = 0;
    log_q.delete();
    run_req(2'b01, 2'b01, 16'h0077, g, code, rd, lat, psel_rsp);
    check("to_code", 32'(code), 32'(RSP_TIMEOUT));
    check("to_access_cycles", 32'(max_acc), TO);
    check("to_latency", 32'(lat), TO + 2);
    check("to_psel_low", 32'(psel_rsp), 0);
    check("to_no_data", 32'(fq.size()), 0);
    ready_en = 1'b1;
    run_req(2'b10, 2'b10, 16'h5A00, g, code, rd, lat, psel_rsp);
    check("after_to_code", 32'(code), 32'(RSP_OK));
    check("after_to_latency", 32'(lat), 7);
    run_req(2'b01, 2'b00, 16'h0000, g, code, rd, lat, psel_rsp);
    check("after_to_pop", {22'b0, code, rd}, {22'b0, RSP_OK, 8'h5A});

    // Reset during the data access phase of a push.
    @(negedge clk);
    req_valid = 2'b01;
    req_write = 2'b01;
    req_wdata = 16'h0099;
    #1;
    check("mid_rst_accept", 32'(req_ready), 1);
    repeat (5) @(negedge clk) req_valid = '0;
    #1;
    check("mid_rst_in_dt_access", {28'b0, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR == 4'h4}, 32'hF);
    last = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_apb_idle", {28'b0, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR != 4'h0}, 0);
    check("mid_rst_outputs", {14'b0, req_ready, rsp_valid, rsp_code, rsp_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_cnt - last), 0);
    check("mid_rst_no_push", 32'(fq.size()), 0);
    run_req(2'b11, 2'b00, 16'h0000, g, code, rd, lat, psel_rsp);
    check("mid_rst_first_grant", 32'(g), 0);
    check("mid_rst_pop_code", 32'(code), 32'(RSP_EMPTY));

    // Randomized requests against a queue model of the peripheral.
    apply_reset();
    last = N - 1;
    mq.delete();
    foreach (fq[i]) mq.push_back(fq[i]);
    for (int it = 0; it < 60; it++) begin
      int eg;
      logic ew;
      logic [7:0] ed;
      logic [1:0] ecode;
      m  = N'($urandom_range(1, (1 << N) - 1));
      w  = N'($urandom);
      wd = (8*N)'($urandom);
      ready_at = $urandom_range(1, 4);
      eg = rr_next(last, m);
      ew = w[eg];
      ed = wd[eg*8 +: 8];
      run_req(m, w, wd, g, code, rd, lat, psel_rsp);
      check($sformatf("rnd%0d_grant", it), 32'(g), 32'(eg));
      if (ew) begin
        ecode = (mq.size() == DEPTH) ? RSP_FULL : RSP_OK;
        if (ecode == RSP_OK) mq.push_back(ed);
        check($sformatf("rnd%0d_push_code", it), 32'(code), 32'(ecode));
      end else begin
        ecode = (mq.size() == 0) ? RSP_EMPTY : RSP_OK;
        check($sformatf("rnd%0d_pop_code", it), 32'(code), 32'(ecode));
        if (ecode == RSP_OK) check($sformatf("rnd%0d_pop_data", it), 32'(rd), 32'(mq.pop_front()));
      end
      last = eg;
    end
    check("rnd_final_depth", 32'(fq.size()), 32'(mq.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_apb_sched.md
Name: fifo_apb_sched

Overview:
- APB master that shares the APB FIFO peripheral between N_CLIENTS local requesters.
- Each request is a push or a pop. Per request the block reads the status register, then issues the data write (push) or data read (pop) only if the FIFO can accept it, and returns a status code to the requester.
- Sits between client logic and the FIFO peripheral's APB slave port; one transaction in flight at a time; round-robin arbitration.

Parameters:
- N_CLIENTS, 2, number of requesters (2..8)
- TIMEOUT, 15, max ACCESS-phase cycles waiting for PREADY before abort
- ADDR_STATUS, 4'h0, status register address (bit1 full, bit0 empty)
- ADDR_WDATA, 4'h4, push data register address
- ADDR_RDATA, 4'h8, pop data register address (a read pops the FIFO)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-low reset
- PADDR  out  4  APB address
- PWDATA  out  32  APB write data, {24'b0, data}
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready, single-cycle pulse from slave
- req_valid  in  N_CLIENTS  per-client request
- req_write  in  N_CLIENTS  1 = push, 0 = pop
- req_wdata  in  N_CLIENTS*8  per-client push byte, client i at [8i+7:8i]
- req_ready  out  N_CLIENTS  one-hot accept pulse
- rsp_valid  out  N_CLIENTS  one-hot completion pulse
- rsp_code  out  2  0 OK, 1 FULL, 2 EMPTY, 3 TIMEOUT; valid with rsp_valid
- rsp_rdata  out  8  popped byte; valid with rsp_valid when pop and OK

Behaviour:
- Reset (PRESET=0 at a PCLK edge): state IDLE, all APB outputs 0, req_ready/rsp_valid 0, rsp_code 0, rsp_rdata 0, rr pointer = N_CLIENTS-1 (client 0 wins first).
  - Reset mid-transaction aborts immediately, with no response to the client.
  - PSEL low on the cycle after the reset edge.
- States: IDLE, ST_SETUP, ST_ACCESS, DT_SETUP, DT_ACCESS, RESP.
- IDLE:
  - If any req_valid: grant by round robin starting after the last grant.
  - Pulse req_ready[g] for 1 cycle; latch g, req_write[g], req_wdata[g].
  - Go to ST_SETUP.
- ST_SETUP: PSEL=1, PENABLE=0, PWRITE=0, PADDR=ADDR_STATUS. Go to ST_ACCESS.
- ST_ACCESS: PSEL=1, PENABLE=1, PADDR and PWRITE held.
  - On PREADY: sample PRDATA[1:0].
    - Push with full=1: code FULL, go to RESP.
    - Pop with empty=1: code EMPTY, go to RESP.
    - Otherwise go to DT_SETUP.
- DT_SETUP: PSEL=1, PENABLE=0.
  - Push: PWRITE=1, PADDR=ADDR_WDATA, PWDATA={24'b0, latched byte}.
  - Pop: PWRITE=0, PADDR=ADDR_RDATA.
- DT_ACCESS: PENABLE=1.
  - On PREADY: code OK.
  - Pop: rsp_rdata = PRDATA[7:0] sampled on the PREADY cycle.
  - Go to RESP.
- RESP: rsp_valid[g]=1 for exactly 1 cycle; PSEL=0; go to IDLE.
  - The rr pointer updates to g.
  - The next grant can occur in the cycle after RESP.
- PSEL/PENABLE drop on the cycle after PREADY is seen. The next SETUP always has PENABLE=0, so the slave never sees back-to-back enabled cycles.
- Timeout:
  - A wait counter clears on entering each ACCESS state and increments on each ACCESS cycle without PREADY.
  - When it reaches TIMEOUT: code TIMEOUT, go to RESP, and the data phase is skipped.
- Latency with a slave that asserts PREADY on the 2nd ACCESS cycle (accept = cycle 0):
  - Full transaction: rsp_valid at cycle 7.
  - FULL/EMPTY early exit: rsp_valid at cycle 4.
- Request rules:
  - req_valid/req_write/req_wdata are sampled only in the req_ready cycle.
  - A client may drop req_valid before grant with no effect.
  - Requests arriving during a transaction wait.
- Simultaneous requests: exactly one grant per IDLE cycle. No client waits more than N_CLIENTS-1 transactions.

Decomposition:
- Package fifo_sched_pkg:
  - state_e (the six states)
  - rsp_code_e (OK/FULL/EMPTY/TIMEOUT)
  - default register address constants
- Sub-module rr_arbiter (N-bit request, last-grant pointer in, one-hot grant out; combinational) instantiated once.
- The FSM and APB drive stay in fifo_apb_sched.

Test Plan:
- Single push: client0 pushes 0xA5 to an empty FIFO peripheral. Required: status read at 0x0, then write at 0x4 with PWDATA=0x000000A5, rsp_code=OK at cycle 7. A subsequent pop returns rsp_rdata=0xA5.
- Pop on empty: client1 pops after reset. Required: only the status read is issued, no access to 0x8, rsp_code=EMPTY at cycle 4.
- Push on full: fill the FIFO to depth, then push 0x3C. Required: rsp_code=FULL, no write at 0x4, FIFO contents unchanged on a subsequent full drain.
- Round robin: both clients hold req_valid continuously, 6 requests total. Required grants 0,1,0,1,0,1, req_ready one-hot, no overlapping rsp_valid.
- Timeout: slave model never asserts PREADY. Required: rsp_code=TIMEOUT after 15 ACCESS cycles, PSEL low the following cycle, next request serviced normally.
- Reset mid-transaction: assert PRESET=0 during DT_ACCESS. Required: outputs return to reset values, no rsp_valid, client 0 granted first after release.
